// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and sizing helper for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mult_seq_control.sv
// rtl/mult_seq_control.sv - FSM and iteration counter driving the multiplier datapath selects
module mult_seq_control
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic i_start,
    input  logic i_neg_req,
    input  logic i_lsb,
    output logic o_load,
    output logic o_add_en,
    output logic o_shift,
    output logic o_negate,
    output logic o_busy,
    output logic o_done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_count;
    logic            r_neg;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_last;

    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_last   = (r_state == ST_RUN) && (r_count == LAST_COUNT);

    // Next-state selection: accept only from IDLE, leave RUN after the final iteration, FIX lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next_state = ST_RUN;
            ST_RUN:  if (w_last)  w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, counter, sign flag and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_last;
            if (w_accept) begin
                r_count <= '0;
                r_neg   <= i_neg_req;
                r_busy  <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_count <= r_count + 1'b1;
            end else if (r_state == ST_FIX) begin
                r_neg   <= 1'b0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign o_load   = w_accept;
    assign o_shift  = (r_state == ST_RUN);
    assign o_add_en = (r_state == ST_RUN) && i_lsb;
    assign o_negate = (r_state == ST_FIX) && r_neg;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - parametrised shift-add multiplier with signed/unsigned mode and start/busy/done handshake
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_load;
    logic               w_add_en;
    logic               w_shift;
    logic               w_negate;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_shifted;
    logic [2*WIDTH-1:0] w_negated;

    // Magnitudes are unsigned WIDTH bits, so the most-negative operand maps cleanly to 2^(WIDTH-1).
    assign w_a_neg = signed_mode & multiplicand[WIDTH-1];
    assign w_b_neg = signed_mode & multiplier[WIDTH-1];
    assign w_mag_a = w_a_neg ? -multiplicand : multiplicand;
    assign w_mag_b = w_b_neg ? -multiplier   : multiplier;

    // Upper half plus optional multiplicand, keeping the carry so the shift can bring it in.
    assign w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (w_add_en ? {1'b0, r_mcand} : '0);
    assign w_shifted = {w_sum, r_prod[WIDTH-1:1]};
    assign w_negated = -r_prod;

    mult_seq_control #(
        .WIDTH (WIDTH)
    ) u_control (
        .clock     (clock),
        .reset     (reset),
        .i_start   (start),
        .i_neg_req (w_a_neg ^ w_b_neg),
        .i_lsb     (r_prod[0]),
        .o_load    (w_load),
        .o_add_en  (w_add_en),
        .o_shift   (w_shift),
        .o_negate  (w_negate),
        .o_busy    (busy),
        .o_done    (done)
    );

    // Product register: load magnitudes on accept, add-and-shift in RUN, sign fix-up in FIX.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prod  <= '0;
            r_mcand <= '0;
        end else if (w_load) begin
            r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
            r_mcand <= w_mag_a;
        end else if (w_shift) begin
            r_prod  <= w_shifted;
        end else if (w_negate) begin
            r_prod  <= w_negated;
        end
    end

    // The fixed-up value is shown during the done cycle and written back at its end, so it never moves afterwards.
    assign product = w_negate ? w_negated : r_prod;

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq at widths 4, 8, 16 and 32
module tb_mult_seq;

    logic clock;
    logic reset;

    logic        st4, sm4, bz4, dn4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        st8, sm8, bz8, dn8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        st16, sm16, bz16, dn16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        st32, sm32, bz32, dn32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    int n_checks;
    int n_errors;

    typedef struct {
        string        name;
        int           w;
        bit           sm;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    vec_t vq[$];

    mult_seq #(.WIDTH(4)) u_w4 (
        .clock(clock), .reset(reset), .start(st4), .signed_mode(sm4),
        .multiplicand(a4), .multiplier(b4), .busy(bz4), .done(dn4), .product(p4));
    mult_seq #(.WIDTH(8)) u_w8 (
        .clock(clock), .reset(reset), .start(st8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8), .busy(bz8), .done(dn8), .product(p8));
    mult_seq #(.WIDTH(16)) u_w16 (
        .clock(clock), .reset(reset), .start(st16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16), .busy(bz16), .done(dn16), .product(p16));
    mult_seq #(.WIDTH(32)) u_w32 (
        .clock(clock), .reset(reset), .start(st32), .signed_mode(sm32),
        .multiplicand(a32), .multiplier(b32), .busy(bz32), .done(dn32), .product(p32));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: mathematical product of the operands' values, truncated to 2*w bits.
    function automatic logic [127:0] ref_mul(input int w, input bit sm, input logic [63:0] a, input logic [63:0] b);
        logic [63:0]         mask;
        logic [63:0]         am, bm;
        longint              sa, sb;
        logic signed [127:0] ps;
        logic [127:0]        p;
        mask = (64'd1 << w) - 64'd1;
        am = a & mask;
        bm = b & mask;
        if (sm) begin
            sa = am[w-1] ? longint'(am) - (longint'(1) <<< w) : longint'(am);
            sb = bm[w-1] ? longint'(bm) - (longint'(1) <<< w) : longint'(bm);
            ps = sa;
            ps = ps * sb;
            p  = ps;
        end else begin
            p = {64'd0, am} * {64'd0, bm};
        end
        return p & ((128'd1 << (2 * w)) - 128'd1);
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (64'd1 << w) - 64'd1;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       r = 64'd0;
            1:       r = mask;
            2:       r = 64'd1 << (w - 1);
            3:       r = 64'd1;
            default: r = r & mask;
        endcase
        return r;
    endfunction

    task automatic set_in(input int w, input logic s, input logic sm, input logic [63:0] a, input logic [63:0] b);
        case (w)
            4:  begin st4  = s; sm4  = sm; a4  = a[3:0];  b4  = b[3:0];  end
            8:  begin st8  = s; sm8  = sm; a8  = a[7:0];  b8  = b[7:0];  end
            16: begin st16 = s; sm16 = sm; a16 = a[15:0]; b16 = b[15:0]; end
            default: begin st32 = s; sm32 = sm; a32 = a[31:0]; b32 = b[31:0]; end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            4:       return bz4;
            8:       return bz8;
            16:      return bz16;
            default: return bz32;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            4:       return dn4;
            8:       return dn8;
            16:      return dn16;
            default: return dn32;
        endcase
    endfunction

    function automatic logic [127:0] get_prod(input int w);
        case (w)
            4:       return 128'(p4);
            8:       return 128'(p8);
            16:      return 128'(p16);
            default: return 128'(p32);
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full operation: accept on the next edge, then count cycles until done (bounded).
    task automatic do_op(input int w, input bit sm, input logic [63:0] a, input logic [63:0] b,
                         output logic [127:0] p, output int lat);
        @(negedge clock);
        set_in(w, 1'b1, sm, a, b);
        @(negedge clock);
        set_in(w, 1'b0, sm, a, b);
        lat = 1;
        while (!get_done(w) && lat < w + 8) begin
            @(negedge clock);
            lat++;
        end
        p = get_prod(w);
    endtask

    task automatic add_vec(input string name, input int w, input bit sm,
                           input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
        vec_t v;
        v.name = name; v.w = w; v.sm = sm; v.a = a; v.b = b; v.exp = exp;
        vq.push_back(v);
    endtask

    initial begin
        logic [127:0] p;
        int           lat;
        int           extra_done;
        int           widths[3];

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        set_in(4, 0, 0, 0, 0);
        set_in(8, 0, 0, 0, 0);
        set_in(16, 0, 0, 0, 0);
        set_in(32, 0, 0, 0, 0);

        add_vec("w32_u_ones",    32, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001);
        add_vec("w8_s_m3x5",      8, 1'b1, 64'hFD, 64'h05, 128'hFFF1);
        add_vec("w8_s_minxmin",   8, 1'b1, 64'h80, 64'h80, 128'h4000);
        add_vec("w8_s_minx1",     8, 1'b1, 64'h80, 64'h01, 128'hFF80);
        add_vec("w8_u_80x80",     8, 1'b0, 64'h80, 64'h80, 128'h4000);
        add_vec("w8_s_80x80_rep", 8, 1'b1, 64'h80, 64'h80, 128'h4000);
        add_vec("w8_s_maxxmin",   8, 1'b1, 64'h7F, 64'h80, 128'hC080);
        add_vec("w4_s_minxmin",   4, 1'b1, 64'h8,  64'h8,  128'h40);
        add_vec("w4_u_fxf",       4, 1'b0, 64'hF,  64'hF,  128'hE1);
        add_vec("w16_u_7x9",     16, 1'b0, 64'd7,  64'd9,  128'd63);
        add_vec("w16_s_m1xm1",   16, 1'b1, 64'hFFFF, 64'hFFFF, 128'h1);
        add_vec("w32_s_m1x2",    32, 1'b1, 64'hFFFF_FFFF, 64'd2, 128'hFFFF_FFFF_FFFF_FFFE);

        repeat (3) @(negedge clock);
        widths[0] = 4; widths[1] = 16; widths[2] = 32;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy_w%0d", widths[k]), 128'(get_busy(widths[k])), 128'd0);
            check($sformatf("rst_done_w%0d", widths[k]), 128'(get_done(widths[k])), 128'd0);
            check($sformatf("rst_prod_w%0d", widths[k]), get_prod(widths[k]), 128'd0);
        end
        reset = 1'b0;

        // Directed table: value and exact accept-to-done latency.
        foreach (vq[i]) begin
            do_op(vq[i].w, vq[i].sm, vq[i].a, vq[i].b, p, lat);
            check({vq[i].name, "_prod"}, p, vq[i].exp);
            check({vq[i].name, "_lat"}, 128'(lat), 128'(vq[i].w + 1));
        end

        // Start pulses during RUN (cycle 3) and in the done cycle are ignored.
        @(negedge clock);
        set_in(8, 1'b1, 1'b0, 64'h12, 64'h34);
        @(negedge clock);
        set_in(8, 1'b0, 1'b0, 64'h12, 64'h34);
        check("ign_busy_c1", 128'(bz8), 128'd1);
        for (int c = 2; c <= 9; c++) begin
            @(negedge clock);
            if (c == 3) set_in(8, 1'b1, 1'b1, 64'hAA, 64'h55);
            if (c == 4) set_in(8, 1'b0, 1'b1, 64'hAA, 64'h55);
        end
        check("ign_done_c9", 128'(dn8), 128'd1);
        check("ign_prod_c9", 128'(p8), 128'h3A8);
        set_in(8, 1'b1, 1'b1, 64'hAA, 64'h55);
        @(negedge clock);
        set_in(8, 1'b0, 1'b1, 64'hAA, 64'h55);
        check("ign_busy_c10", 128'(bz8), 128'd0);
        check("ign_done_c10", 128'(dn8), 128'd0);
        check("ign_prod_c10", 128'(p8), 128'h3A8);
        repeat (3) @(negedge clock);
        check("ign_still_idle", 128'(bz8), 128'd0);
        check("ign_prod_hold", 128'(p8), 128'h3A8);
        do_op(8, 1'b1, 64'hAA, 64'h55, p, lat);
        check("ign_next_prod", p, ref_mul(8, 1'b1, 64'hAA, 64'h55));
        check("ign_next_lat", 128'(lat), 128'd9);

        // Reset in cycle 5 of a WIDTH=16 operation discards it.
        @(negedge clock);
        set_in(16, 1'b1, 1'b0, 64'h1234, 64'h5678);
        @(negedge clock);
        set_in(16, 1'b0, 1'b0, 64'h1234, 64'h5678);
        for (int c = 2; c <= 5; c++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rstmid_busy", 128'(bz16), 128'd0);
        check("rstmid_prod", 128'(p16), 128'd0);
        check("rstmid_done", 128'(dn16), 128'd0);
        reset = 1'b0;
        extra_done = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            if (dn16) extra_done++;
        end
        check("rstmid_no_done", 128'(extra_done), 128'd0);
        do_op(16, 1'b0, 64'd7, 64'd9, p, lat);
        check("rstmid_7x9_prod", p, 128'd63);
        check("rstmid_7x9_lat", 128'(lat), 128'd17);

        // Random regression against the arithmetic reference.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [63:0] ra, rb;
                bit          rsm;
                ra  = pick(widths[k]);
                rb  = pick(widths[k]);
                rsm = bit'($urandom_range(0, 1));
                do_op(widths[k], rsm, ra, rb, p, lat);
                check($sformatf("rnd_w%0d_prod a=%0h b=%0h s=%0d", widths[k], ra, rb, rsm),
                      p, ref_mul(widths[k], rsm, ra, rb));
                check($sformatf("rnd_w%0d_lat", widths[k]), 128'(lat), 128'(widths[k] + 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
